// File: rtl/range_counter.sv
// Candidate-index generator: walks [start_value, end_value] by a runtime stride and
// presents each index over valid/ready. Define RANGE_COUNTER_STATS_EN to add the issued-beat counter.
module range_counter #(
  parameter int WIDTH  = 32,
  parameter int SWIDTH = 8    // must not exceed WIDTH
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              load,
  input  logic [WIDTH-1:0]  start_value,
  input  logic [WIDTH-1:0]  end_value,
  input  logic [SWIDTH-1:0] stride,
  input  logic              enable,
  input  logic              step,
  input  logic              abort,
  input  logic              count_ready,
  output logic [WIDTH-1:0]  count,
  output logic              count_valid,
  output logic              running,
  output logic              done,
  output logic              range_err
`ifdef RANGE_COUNTER_STATS_EN
  ,
  output logic [WIDTH-1:0]  issued
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_STEP,
    S_RUN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    end_q, end_d;
  logic [SWIDTH-1:0]   stride_q, stride_d;
  logic                range_err_q, range_err_d;
  logic                count_valid_q, count_valid_d;
  logic                running_q, running_d;
  logic                done_q, done_d;

  logic                handshake;
  logic                load_ok;
  logic                last;
  logic [WIDTH:0]      remain;
  logic [WIDTH:0]      stride_ext;

  assign handshake  = count_valid_q & count_ready;
  assign load_ok    = load & (state_q inside {S_IDLE, S_ARMED, S_DONE});

  // One bit of headroom so the end-of-range test never wraps at the top of the index space.
  assign stride_ext = {{(WIDTH + 1 - SWIDTH){1'b0}}, stride_q};
  assign remain     = {1'b0, end_q} - {1'b0, count_q};
  assign last       = (remain < stride_ext);

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    state_d     = state_q;
    count_d     = count_q;
    end_d       = end_q;
    stride_d    = stride_q;
    range_err_d = range_err_q;

    if (abort) begin
      state_d     = S_IDLE;
      count_d     = '0;
      range_err_d = 1'b0;
    end else if (load_ok) begin
      count_d = start_value;
      if (start_value <= end_value) begin
        end_d       = end_value;
        stride_d    = (stride == '0) ? SWIDTH'(1) : stride;
        range_err_d = 1'b0;
        state_d     = S_ARMED;
      end else begin
        range_err_d = 1'b1;
        state_d     = S_DONE;
      end
    end else begin
      case (state_q)
        S_ARMED: begin
          if (enable) begin
            state_d = S_RUN;
          end else if (step) begin
            state_d = S_STEP;
          end
        end
        S_STEP: begin
          if (handshake) begin
            if (last) begin
              state_d = S_DONE;
            end else begin
              count_d = count_q + stride_ext[WIDTH-1:0];
              state_d = S_ARMED;
            end
          end
        end
        S_RUN: begin
          // Without a handshake the beat is held, whatever enable does.
          if (handshake) begin
            if (last) begin
              state_d = S_DONE;
            end else begin
              count_d = count_q + stride_ext[WIDTH-1:0];
              state_d = enable ? S_RUN : S_ARMED;
            end
          end
        end
        default: begin
        end
      endcase
    end

    count_valid_d = (state_d == S_STEP) || (state_d == S_RUN);
    running_d     = (state_d == S_RUN);
    done_d        = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      end_q         <= '0;
      stride_q      <= SWIDTH'(1);
      range_err_q   <= 1'b0;
      count_valid_q <= 1'b0;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q       <= state_d;
      count_q       <= count_d;
      end_q         <= end_d;
      stride_q      <= stride_d;
      range_err_q   <= range_err_d;
      count_valid_q <= count_valid_d;
      running_q     <= running_d;
      done_q        <= done_d;
    end
  end

  assign count       = count_q;
  assign count_valid = count_valid_q;
  assign running     = running_q;
  assign done        = done_q;
  assign range_err   = range_err_q;

`ifdef RANGE_COUNTER_STATS_EN
  logic [WIDTH-1:0] issued_q, issued_d;
  logic             beat;
  logic             stats_clear;

  // An aborted cycle drops its beat; load is never accepted while a beat is presented.
  assign beat        = handshake & ~abort;
  assign stats_clear = abort | load_ok;

  always_comb begin
    issued_d = issued_q;
    if (stats_clear) begin
      issued_d = '0;
    end else if (beat && (issued_q != '1)) begin
      issued_d = issued_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      issued_q <= '0;
    end else begin
      issued_q <= issued_d;
    end
  end

  assign issued = issued_q;
`endif

  // A presented candidate is always inside the range and holds until it is taken.
  a_in_range: assert property (@(posedge CLK) disable iff (!reset_n)
    count_valid_q |-> (count_q <= end_q));
  a_hold: assert property (@(posedge CLK) disable iff (!reset_n)
    (count_valid_q && !count_ready && !abort) |=> (count_valid_q && $stable(count_q)));

endmodule

// File: tb/tb_range_counter.sv
// Bench for range_counter: directed scenarios plus randomized traffic, all checked against a
// candidate-list reference model. Build with RANGE_COUNTER_STATS_EN to also check issued.
module tb_range_counter;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b1;
  logic        load = 1'b0;
  logic [31:0] start_value = '0;
  logic [31:0] end_value = '0;
  logic [7:0]  stride = '0;
  logic        enable = 1'b0;
  logic        step = 1'b0;
  logic        abort = 1'b0;
  logic        count_ready = 1'b0;
  logic [31:0] count;
  logic        count_valid;
  logic        running;
  logic        done;
  logic        range_err;
`ifdef RANGE_COUNTER_STATS_EN
  logic [31:0] issued;
`endif

  range_counter #(.WIDTH(32), .SWIDTH(8)) dut (
    .CLK         (CLK),
    .reset_n     (reset_n),
    .load        (load),
    .start_value (start_value),
    .end_value   (end_value),
    .stride      (stride),
    .enable      (enable),
    .step        (step),
    .abort       (abort),
    .count_ready (count_ready),
    .count       (count),
    .count_valid (count_valid),
    .running     (running),
    .done        (done),
    .range_err   (range_err)
`ifdef RANGE_COUNTER_STATS_EN
    ,
    .issued      (issued)
`endif
  );

  initial forever #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference model: on a good load the whole candidate list is computed up front;
  // each accepted beat pops the head, the head is what count must show.
  typedef enum {M_IDLE, M_WAIT, M_ONE, M_FREE, M_END} mphase_e;
  mphase_e           m_phase;
  logic [31:0]       m_count;
  bit                m_err;
  longint unsigned   m_todo[$];
  longint unsigned   m_issued;

  task automatic model_reset();
    m_phase  = M_IDLE;
    m_count  = '0;
    m_err    = 1'b0;
    m_issued = 0;
    m_todo.delete();
  endtask

  task automatic model_step();
    bit presenting;
    longint unsigned inc;
    presenting = (m_phase == M_ONE) || (m_phase == M_FREE);
    if (abort) begin
      model_reset();
    end else if (load && (m_phase == M_IDLE || m_phase == M_WAIT || m_phase == M_END)) begin
      m_issued = 0;
      m_count  = start_value;
      m_todo.delete();
      if (start_value <= end_value) begin
        inc = (stride == 8'd0) ? 64'd1 : 64'(stride);
        for (longint unsigned v = 64'(start_value); v <= 64'(end_value); v += inc)
          m_todo.push_back(v);
        m_err   = 1'b0;
        m_phase = M_WAIT;
      end else begin
        m_err   = 1'b1;
        m_phase = M_END;
      end
    end else if (m_phase == M_WAIT) begin
      if (enable) m_phase = M_FREE;
      else if (step) m_phase = M_ONE;
    end else if (presenting && count_ready) begin
      void'(m_todo.pop_front());
      if (m_issued != 64'hFFFF_FFFF) m_issued++;
      if (m_todo.size() == 0) begin
        m_phase = M_END;
      end else begin
        m_count = m_todo[0][31:0];
        if (m_phase == M_ONE || !enable) m_phase = M_WAIT;
      end
    end
  endtask

  task automatic compare_all();
    check("count", count, m_count);
    check("count_valid", count_valid, (m_phase == M_ONE) || (m_phase == M_FREE));
    check("running", running, m_phase == M_FREE);
    check("done", done, m_phase == M_END);
    check("range_err", range_err, m_err);
`ifdef RANGE_COUNTER_STATS_EN
    check("issued", issued, m_issued);
`endif
  endtask

  logic [31:0] got[$];
  logic [31:0] exp_q[$];
  bit          valid_seen;

  // Inputs change 1 time unit after a rising edge; outputs are compared there too.
  task automatic tick();
    if (reset_n && count_valid && count_ready && !abort) got.push_back(count);
    if (count_valid) valid_seen = 1'b1;
    @(posedge CLK);
    if (reset_n) model_step();
    #1;
    compare_all();
  endtask

  task automatic do_load(input logic [31:0] s, input logic [31:0] e, input logic [7:0] st);
    load        = 1'b1;
    start_value = s;
    end_value   = e;
    stride      = st;
    tick();
    load = 1'b0;
  endtask

  task automatic compare_beats(input string tag);
    check({tag, "_nbeats"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), got[i], exp_q[i]);
    got.delete();
  endtask

  initial begin
    model_reset();
    #1 reset_n = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_valid", count_valid, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_err", range_err, 0);
    @(posedge CLK);
    #1 reset_n = 1'b1;

    // Free run over a short range with ready held: two-cycle load latency, then one per cycle.
    got.delete();
    enable = 1'b1;
    count_ready = 1'b1;
    do_load(32'h10, 32'h13, 8'd1);
    check("lat_armed_valid", count_valid, 0);
    tick();
    check("lat_run_valid", count_valid, 1);
    check("lat_run_count", count, 32'h10);
    repeat (5) tick();
    exp_q = '{32'h10, 32'h11, 32'h12, 32'h13};
    compare_beats("run4");
    check("run4_done", done, 1);
    check("run4_running", running, 0);

    // Top of the index space: no wrap past 0xFFFFFFFF.
    do_load(32'hFFFF_FFFC, 32'hFFFF_FFFF, 8'd3);
    repeat (6) tick();
    exp_q = '{32'hFFFF_FFFC, 32'hFFFF_FFFF};
    compare_beats("top");
    check("top_done", done, 1);
    check("top_count", count, 32'hFFFF_FFFF);

    // Stall in RUN: ready 1,0,0,1 holds 0x11.
    do_load(32'h10, 32'h13, 8'd1);
    tick();
    tick();
    count_ready = 1'b0;
    tick();
    check("stall_count1", count, 32'h11);
    check("stall_valid1", count_valid, 1);
    tick();
    check("stall_count2", count, 32'h11);
    count_ready = 1'b1;
    repeat (5) tick();
    exp_q = '{32'h10, 32'h11, 32'h12, 32'h13};
    compare_beats("stall");

    // Single step with stride 0 treated as 1; extra step pulses while presenting are ignored.
    enable = 1'b0;
    count_ready = 1'b0;
    do_load(32'd5, 32'd9, 8'd0);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      tick();
      tick();
      step = 1'b0;
      count_ready = 1'b1;
      tick();
      count_ready = 1'b0;
      check($sformatf("step%0d_armed_valid", k), count_valid, 0);
      check($sformatf("step%0d_next", k), count, 32'd6 + 32'(k));
    end
    tick();
    exp_q = '{32'd5, 32'd6, 32'd7};
    compare_beats("step");

    // Reversed range: error flagged, nothing ever presented, enable ignored.
    enable = 1'b1;
    count_ready = 1'b1;
    do_load(32'd9, 32'd5, 8'd1);
    valid_seen = 1'b0;
    repeat (4) tick();
    check("rerr_flag", range_err, 1);
    check("rerr_done", done, 1);
    check("rerr_no_valid", valid_seen, 0);
    exp_q.delete();
    compare_beats("rerr");

    // Abort with a pending handshake drops the beat.
    count_ready = 1'b0;
    do_load(32'h20, 32'h40, 8'd1);
    tick();
    check("abort_pre_count", count, 32'h20);
    abort = 1'b1;
    count_ready = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_count", count, 0);
    check("abort_valid", count_valid, 0);
    repeat (3) tick();
    exp_q.delete();
    compare_beats("abort");

    // Asynchronous reset in the middle of RUN clears outputs without a clock edge.
    do_load(32'h20, 32'h40, 8'd1);
    repeat (3) tick();
    #3 reset_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_valid", count_valid, 0);
    check("arst_running", running, 0);
    check("arst_done", done, 0);
    check("arst_err", range_err, 0);
    model_reset();
    got.delete();
    @(posedge CLK);
    #1;
    compare_all();
    reset_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      int r;
      int span;
      abort = ($urandom_range(0, 99) < 2);
      load  = ($urandom_range(0, 99) < 8);
      if (load) begin
        r    = $urandom_range(0, 99);
        span = $urandom_range(0, 40);
        if (r < 15) begin
          end_value   = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
          start_value = end_value - 32'(span);
        end else if (r < 88) begin
          start_value = $urandom;
          if (start_value > 32'hFFFF_FFFF - 32'(span)) end_value = 32'hFFFF_FFFF;
          else end_value = start_value + 32'(span);
        end else begin
          start_value = $urandom | 32'h100;
          end_value   = start_value - 32'd1 - 32'(span);
        end
        r = $urandom_range(0, 99);
        if (r < 20) stride = 8'd0;
        else if (r < 30) stride = 8'($urandom_range(100, 255));
        else stride = 8'($urandom_range(1, 8));
      end
      enable      = ($urandom_range(0, 99) < 60);
      step        = ($urandom_range(0, 99) < 25);
      count_ready = ($urandom_range(0, 99) < 70);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/range_counter.md
Name: range_counter

Overview:
- Parametrised candidate-index generator for the MD5 brute-force datapath; successor to the free-running 32-bit search counter.
- Walks a loaded range [start, end] in steps of a runtime stride, so N hash lanes can each cover an interleaved slice.
- Presents each candidate to the downstream hash core over a valid/ready handshake.
- Supports free-run, single-step, abort and reload, and flags completion.

Parameters:
- WIDTH, 32, candidate index width in bits.
- SWIDTH, 8, stride input width in bits.

Ports:
- CLK  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load  in  1  capture start_value/end_value/stride.
- start_value  in  WIDTH  first candidate.
- end_value  in  WIDTH  last candidate bound, inclusive.
- stride  in  SWIDTH  increment per beat; 0 is treated as 1.
- enable  in  1  free-run request.
- step  in  1  single-candidate request, pulse.
- abort  in  1  terminate and return to IDLE.
- count_ready  in  1  downstream accepts the candidate.
- count  out  WIDTH  current candidate.
- count_valid  out  1  count is valid for the downstream core.
- running  out  1  high in RUN.
- done  out  1  range exhausted.
- range_err  out  1  last load had start_value > end_value.

Behaviour:
- Reset (reset_n=0, async): state=IDLE; count=0; count_valid, running, done, range_err all 0; end_reg=0; stride_reg=1.
- States: IDLE, ARMED, STEP, RUN, DONE. All outputs are registered.
- Input priority each cycle: abort > load > enable > step.
- abort (any state) -> IDLE next cycle. count=0, all flags 0, any pending beat dropped.
- load is accepted in IDLE, ARMED and DONE; it is ignored in STEP and RUN.
  - start_value <= end_value: count<=start_value, end_reg<=end_value, stride_reg<=(stride==0 ? 1 : stride), range_err<=0, done<=0, -> ARMED.
  - start_value > end_value: range_err<=1, done<=1, -> DONE. count is loaded but never presented as valid.
- IDLE: no outputs asserted; enable and step are ignored.
- ARMED: count_valid=0.
  - enable=1 -> RUN.
  - else step=1 -> STEP.
- STEP: count_valid=1 until handshake (count_valid & count_ready).
  - On handshake: if last, -> DONE; else count<=count+stride_reg and -> ARMED.
  - Further step pulses while in STEP are ignored.
- RUN: running=1, count_valid=1.
  - One candidate per handshake; zero-bubble back-to-back when count_ready is held high.
  - Without a handshake, count and count_valid hold stable, regardless of enable.
  - On handshake: if last, -> DONE, running=0. Else count<=count+stride_reg; if enable=0 -> ARMED, else stay in RUN.
- "last": (end_reg - count) < stride_reg, evaluated in WIDTH+1-bit unsigned arithmetic.
  - count never exceeds end_reg.
  - No wrap-around, including end_value = 2^WIDTH-1.
- DONE: done=1, count_valid=0, running=0; count holds the last issued candidate.
- Latency:
  - load -> first count_valid: 2 cycles with enable held (ARMED, then RUN).
  - handshake -> next count: 1 cycle.
- Simultaneous load and enable in the same cycle: load wins; enable is sampled again in ARMED.

Optional Feature:
- Macro: RANGE_COUNTER_STATS_EN.
- Defined: adds output issued [WIDTH] = number of handshakes since the last load or abort.
  - Cleared by reset, load and abort.
  - Saturates at 2^WIDTH-1.
  - Counts STEP and RUN beats.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- load start=0x10, end=0x13, stride=1, enable held, count_ready=1 -> count 0x10,0x11,0x12,0x13 on consecutive cycles; done=1 the cycle after 0x13 is accepted; running drops with it.
- WIDTH=32, load start=0xFFFFFFFC, end=0xFFFFFFFF, stride=3, enable, ready=1 -> beats 0xFFFFFFFC, 0xFFFFFFFF, then done; no wrap to 0x2.
- RUN with count_ready toggling 1,0,0,1 -> count holds 0x11 with count_valid=1 across the stalled cycles; no candidate skipped or duplicated.
- load start=5, end=9, stride=0; step pulsed three times -> beats 5, 6, 7, each gated by ready; state returns to ARMED between pulses.
- load start=9, end=5 -> range_err=1, done=1, count_valid never asserted; enable ignored.
- RUN at count=0x20 with abort=1 and count_ready=1 in the same cycle -> IDLE next cycle, count=0, no further beats. Then assert reset_n=0 mid-RUN -> all outputs 0 immediately, with no clock edge needed.
